inst_req_stage: RTL and testbench
=================================

// Module: inst_req_stage
// PURPOSE
//  PC generator and instruction-request front end, directly upstream of fetch_stage.
//  Issues sequential or redirected fetch requests on an SRAM-like addr_ok/data_ok bus.
//  Tracks outstanding requests, drops responses to requests killed by a redirect,
//  and buffers responses while fetch is stalled/stopped.
//  Drives fetch_stage's inst_data_ok/inst_addr/inst_rdata with at most one beat per cycle.
// PARAMETERS
//  RESET_PC  32'hbfc00000  PC after reset
//  EXC_PC    32'hbfc00380  redirect target on exception
//  DEPTH     2             max requests in flight + buffered responses (power of 2, >=2)
// PORTS
//  clk            in   1   clock, all state on posedge
//  resetn         in   1   asynchronous, active-low reset
//  stall          in   1   downstream stall (same signal fetch_stage sees)
//  stop           in   1   global freeze; outranks everything except reset
//  exception      in   1   redirect to EXC_PC
//  eret           in   1   redirect to epc
//  epc            in   32  eret target
//  br_taken       in   1   redirect to br_target
//  br_target      in   32  branch/jump target
//  inst_req       out  1   request valid to instruction memory
//  inst_req_addr  out  32  request address (= pc)
//  inst_addr_ok   in   1   memory accepted request this cycle
//  mem_data_ok    in   1   memory returns one response this cycle (in request order)
//  mem_rdata      in   32  response data
//  inst_data_ok   out  1   beat valid to fetch_stage
//  inst_addr      out  32  PC of that beat
//  inst_rdata     out  32  instruction of that beat
// BEHAVIOUR
//  Reset (async): pc=RESET_PC; addr queue, resp FIFO, discard_cnt cleared; all outputs 0
//   except inst_req_addr=RESET_PC.
//  redirect = ~stop & (exception|eret|br_taken); target priority exception > eret > br_taken.
//  inflight = addr_q_count + discard_cnt; total = inflight + resp_count.
//  inst_req = ~stop & ~stall & ~redirect & (total < DEPTH). Held until addr_ok.
//  Accept (inst_req & inst_addr_ok): push pc to addr queue; pc <= pc+4 (wraps mod 2^32).
//  Redirect cycle: pc <= target; no request issued; addr queue and resp FIFO flushed;
//   discard_cnt <= discard_cnt + addr_q_count - mem_data_ok (response this cycle is dropped);
//   inst_data_ok forced 0.
//  mem_data_ok (no redirect): if discard_cnt!=0, decrement it and drop the data;
//   else pop addr queue head and push {addr,mem_rdata} into resp FIFO.
//   mem_data_ok with inflight==0 is a protocol error: ignored, no state change.
//  Output: inst_data_ok = resp_valid & ~stop & ~stall & ~redirect; inst_addr/inst_rdata =
//   resp FIFO head (registered, not bypassed). Pop when inst_data_ok=1.
//   Latency: mem_data_ok in cycle N -> inst_data_ok earliest cycle N+1.
//  Simultaneous push and pop on resp FIFO legal; count unchanged. Full FIFO cannot overflow
//   because total<DEPTH gates new requests.
//  stop: pc, queues and counters frozen except mem_data_ok bookkeeping (bus keeps responding).
//  Outputs change only on posedge clk or async reset; no comb path mem_rdata->inst_rdata.
// TESTING
//  1 reset, stall=0, addr_ok/data_ok fire 1 cycle after req -> fetch sees PCs bfc00000,
//    bfc00004, bfc00008 in order with matching data, one beat/cycle steady state.
//  2 addr_ok held low 5 cycles -> inst_req=1 and inst_req_addr stable all 5 cycles.
//  3 two requests in flight, br_taken to 0x80001000 -> both old responses dropped,
//    first delivered beat has inst_addr=0x80001000.
//  4 stall=1 for 6 cycles with 2 in flight -> 2 responses buffered, no new req, inst_data_ok=0;
//    stall release -> 2 beats delivered consecutively, then requests resume.
//  5 exception and eret same cycle, epc=0x80002000 -> pc=bfc00380; stop=1 same cycle -> no redirect.
//  6 async resetn pulse mid-burst (between clocks) -> outputs cleared immediately, restart at RESET_PC.

Source files
------------

// File: rtl/inst_req_stage.sv
// inst_req_stage: PC generator and instruction-request front end feeding fetch_stage.
// Issues sequential or redirected requests on an addr_ok/data_ok memory bus, tracks
// outstanding requests, discards responses belonging to killed requests and buffers
// responses while the downstream stage is stalled or the pipeline is stopped.
module inst_req_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] EXC_PC   = 32'hbfc00380,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        stop,
    input  logic        exception,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_req,
    output logic [31:0] inst_req_addr,
    input  logic        inst_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        inst_data_ok,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_rdata
);

    // Pointer width for DEPTH entries; counters get two spare bits so that sums of
    // counters (inflight, total) never wrap.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;

    // Architectural PC and a flag that holds off the first request until the first
    // clock edge after reset, so every output is 0 while reset is applied.
    logic [31:0]   pc_reg;
    logic          run_reg;

    // Address queue: PCs of requests accepted by memory and not yet answered.
    logic [31:0]   aq_mem [DEPTH];
    logic [PW-1:0] aq_wr_ptr_reg;
    logic [PW-1:0] aq_rd_ptr_reg;
    logic [CW-1:0] aq_count_reg;

    // Response FIFO: {pc, instruction} pairs waiting for fetch_stage.
    logic [31:0]   rq_addr_mem [DEPTH];
    logic [31:0]   rq_data_mem [DEPTH];
    logic [PW-1:0] rq_wr_ptr_reg;
    logic [PW-1:0] rq_rd_ptr_reg;
    logic [CW-1:0] rq_count_reg;

    // Number of in-flight requests whose responses must be thrown away.
    logic [CW-1:0] discard_cnt_reg;

    logic          redirect;
    logic [31:0]   redirect_target;
    logic [CW-1:0] inflight;
    logic [CW-1:0] total;
    logic          accept;
    logic          data_fire;
    logic          drop;
    logic          keep;
    logic          rq_pop;

    // Redirect decode; stop suppresses redirects entirely.
    always_comb begin
        redirect        = ~stop & (exception | eret | br_taken);
        redirect_target = br_target;
        if (exception) begin
            redirect_target = EXC_PC;
        end else if (eret) begin
            redirect_target = epc;
        end
    end

    // Occupancy: a response slot is reserved from request acceptance until the beat
    // leaves, so the response FIFO can never overflow.
    assign inflight  = aq_count_reg + discard_cnt_reg;
    assign total     = inflight + rq_count_reg;

    assign inst_req      = run_reg & ~stop & ~stall & ~redirect & (total < CW'(DEPTH));
    assign inst_req_addr = pc_reg;
    assign accept        = inst_req & inst_addr_ok;

    // A response with nothing outstanding is a bus protocol error and is ignored.
    assign data_fire = mem_data_ok & (inflight != '0);
    assign drop      = data_fire & (discard_cnt_reg != '0);
    assign keep      = data_fire & ~drop & ~redirect;

    // Beats come only from the registered FIFO head: no path from mem_rdata.
    assign inst_data_ok = (rq_count_reg != '0) & ~stop & ~stall & ~redirect;
    assign inst_addr    = rq_addr_mem[rq_rd_ptr_reg];
    assign inst_rdata   = rq_data_mem[rq_rd_ptr_reg];
    assign rq_pop       = inst_data_ok;

    // PC update: redirect target wins, otherwise advance on each accepted request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_reg  <= RESET_PC;
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (redirect) begin
                pc_reg <= redirect_target;
            end else if (accept) begin
                pc_reg <= pc_reg + 32'd4;
            end
        end
    end

    // Address queue pointers and count; a redirect flushes it (its entries move into
    // discard_cnt).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aq_wr_ptr_reg <= '0;
            aq_rd_ptr_reg <= '0;
            aq_count_reg  <= '0;
        end else if (redirect) begin
            aq_wr_ptr_reg <= '0;
            aq_rd_ptr_reg <= '0;
            aq_count_reg  <= '0;
        end else begin
            if (accept) begin
                aq_wr_ptr_reg <= aq_wr_ptr_reg + PW'(1);
            end
            if (keep) begin
                aq_rd_ptr_reg <= aq_rd_ptr_reg + PW'(1);
            end
            aq_count_reg <= aq_count_reg + CW'(accept) - CW'(keep);
        end
    end

    // Address queue storage: record the PC of each accepted request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                aq_mem[i] <= '0;
            end
        end else if (accept) begin
            aq_mem[aq_wr_ptr_reg] <= pc_reg;
        end
    end

    // Discard counter: absorbs the whole address queue on redirect (minus a response
    // arriving in that same cycle), then counts down as stale responses arrive.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_cnt_reg <= '0;
        end else if (redirect) begin
            discard_cnt_reg <= discard_cnt_reg + aq_count_reg - CW'(data_fire);
        end else if (drop) begin
            discard_cnt_reg <= discard_cnt_reg - CW'(1);
        end
    end

    // Response FIFO pointers and count; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rq_wr_ptr_reg <= '0;
            rq_rd_ptr_reg <= '0;
            rq_count_reg  <= '0;
        end else if (redirect) begin
            rq_wr_ptr_reg <= '0;
            rq_rd_ptr_reg <= '0;
            rq_count_reg  <= '0;
        end else begin
            if (keep) begin
                rq_wr_ptr_reg <= rq_wr_ptr_reg + PW'(1);
            end
            if (rq_pop) begin
                rq_rd_ptr_reg <= rq_rd_ptr_reg + PW'(1);
            end
            rq_count_reg <= rq_count_reg + CW'(keep) - CW'(rq_pop);
        end
    end

    // Response FIFO storage: pair the returned instruction with its request PC.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                rq_addr_mem[i] <= '0;
                rq_data_mem[i] <= '0;
            end
        end else if (keep) begin
            rq_addr_mem[rq_wr_ptr_reg] <= aq_mem[aq_rd_ptr_reg];
            rq_data_mem[rq_wr_ptr_reg] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_req_stage.sv
// Bench for inst_req_stage: a behavioural memory answers accepted requests in order
// after a programmable latency with data = ~address; directed scenarios push the
// expected beat PCs into a queue and an independent monitor checks every beat.
module tb_inst_req_stage;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] EXC_PC   = 32'hbfc00380;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall, stop, exception, eret, br_taken;
    logic [31:0] epc, br_target;
    logic        inst_req;
    logic [31:0] inst_req_addr;
    logic        inst_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;

    inst_req_stage #(
        .RESET_PC(RESET_PC),
        .EXC_PC  (EXC_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall        (stall),
        .stop         (stop),
        .exception    (exception),
        .eret         (eret),
        .epc          (epc),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .inst_req     (inst_req),
        .inst_req_addr(inst_req_addr),
        .inst_addr_ok (inst_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .inst_data_ok (inst_data_ok),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          budget = 0;
    bit          addr_hold = 1'b0;
    int          mem_lat = 1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_q[$];
    int          beat_cyc[$];
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Memory model: drives addr_ok/data_ok shortly after each posedge, records
    // accepted requests mid-cycle.
    initial begin
        inst_addr_ok = 1'b0;
        mem_data_ok  = 1'b0;
        mem_rdata    = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            mem_data_ok = 1'b0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                mem_data_ok = 1'b1;
                mem_rdata   = ~pend_addr[0];
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            inst_addr_ok = (budget > 0) && !addr_hold;
            @(negedge clk);
            if (resetn && inst_req && inst_addr_ok) begin
                pend_addr.push_back(inst_req_addr);
                pend_due.push_back(cyc + mem_lat);
                budget--;
            end
        end
    end

    // Monitor: every beat handed to fetch must match the next expected PC.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && inst_data_ok) begin
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got addr %h expected no beat", inst_addr);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat_addr", inst_addr, mon_exp);
                    check("beat_data", inst_rdata, ~mon_exp);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || pend_due.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_accepts(input string name);
        int n = 0;
        while (budget != 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, 32'(budget), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; stall = 1'b0; stop = 1'b0; exception = 1'b0; eret = 1'b0;
        br_taken = 1'b0; epc = '0; br_target = '0;
        repeat (3) @(negedge clk);
        check("rst_inst_req", 32'(inst_req), 32'd0);
        check("rst_req_addr", inst_req_addr, RESET_PC);
        check("rst_data_ok", 32'(inst_data_ok), 32'd0);
        check("rst_inst_addr", inst_addr, 32'd0);
        check("rst_inst_rdata", inst_rdata, 32'd0);
        tick();
        resetn = 1'b1;

        // 1: sequential fetch, one beat per cycle in steady state
        mem_lat = 1;
        beat_cyc.delete();
        exp_q.push_back(32'hbfc00000);
        exp_q.push_back(32'hbfc00004);
        exp_q.push_back(32'hbfc00008);
        budget = 3;
        quiesce("t1_drain");
        check("t1_beats", 32'(beat_cyc.size()), 32'd3);
        if (beat_cyc.size() == 3) begin
            check("t1_consec_1", 32'(beat_cyc[1] - beat_cyc[0]), 32'd1);
            check("t1_consec_2", 32'(beat_cyc[2] - beat_cyc[1]), 32'd1);
        end

        // 2: addr_ok withheld for 5 cycles, request must hold steady
        addr_hold = 1'b1;
        budget = 1;
        exp_q.push_back(32'hbfc0000c);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_req_held", 32'(inst_req), 32'd1);
            check("t2_addr_stable", inst_req_addr, 32'hbfc0000c);
        end
        addr_hold = 1'b0;
        quiesce("t2_drain");

        // 3: branch with two requests in flight kills both responses
        mem_lat = 4;
        budget = 2;
        wait_accepts("t3_accepts");
        br_taken = 1'b1;
        br_target = 32'h80001000;
        tick();
        br_taken = 1'b0;
        exp_q.push_back(32'h80001000);
        budget = 1;
        quiesce("t3_drain");

        // 4: stall buffers two responses, then they leave back to back
        mem_lat = 2;
        beat_cyc.delete();
        exp_q.push_back(32'h80001004);
        exp_q.push_back(32'h80001008);
        exp_q.push_back(32'h8000100c);
        budget = 2;
        wait_accepts("t4_accepts");
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_no_beat", 32'(inst_data_ok), 32'd0);
            check("t4_no_req", 32'(inst_req), 32'd0);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        budget = 1;
        quiesce("t4_drain");
        check("t4_beats", 32'(beat_cyc.size()), 32'd3);
        if (beat_cyc.size() >= 2) begin
            check("t4_consec", 32'(beat_cyc[1] - beat_cyc[0]), 32'd1);
        end

        // 5: exception outranks eret; stop suppresses redirect
        exception = 1'b1;
        eret = 1'b1;
        epc = 32'h80002000;
        tick();
        exception = 1'b0;
        eret = 1'b0;
        @(negedge clk);
        check("t5_exc_pc", inst_req_addr, EXC_PC);
        @(posedge clk);
        #1;
        stop = 1'b1;
        exception = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h12345678;
        @(negedge clk);
        check("t5_stop_no_req", 32'(inst_req), 32'd0);
        @(posedge clk);
        #1;
        stop = 1'b0;
        exception = 1'b0;
        br_taken = 1'b0;
        @(negedge clk);
        check("t5_pc_frozen", inst_req_addr, EXC_PC);
        check("t5_req_resume", 32'(inst_req), 32'd1);
        @(posedge clk);
        #1;
        budget = 1;
        exp_q.push_back(EXC_PC);
        quiesce("t5_drain");

        // 6: asynchronous reset between clocks mid-burst
        mem_lat = 3;
        budget = 3;
        wait_accepts("t6_accepts");
        #2;
        resetn = 1'b0;
        #1;
        check("t6_req", 32'(inst_req), 32'd0);
        check("t6_req_addr", inst_req_addr, RESET_PC);
        check("t6_data_ok", 32'(inst_data_ok), 32'd0);
        check("t6_rdata", inst_rdata, 32'd0);
        pend_addr.delete();
        pend_due.delete();
        mem_data_ok = 1'b0;
        budget = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        budget = 1;
        exp_q.push_back(RESET_PC);
        quiesce("t6_restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
